u_lsu: RTL and testbench
========================

Name: u_lsu

Overview:
Load/store controller and data-SRAM arbiter between the execute stage and data SRAM1. It sequences core loads and stores onto the single SRAM port, which has a 1-cycle read latency. It aligns store lanes, and extracts and sign/zero-extends load data. It also shares the port with a word-wide debug/DMA requester, with a starvation guard. The exe stage stalls on `stall` until `ack`.

Parameters:
STARVE_MAX, 4, consecutive contested IDLE cycles the debug port may lose before it is granted once.
AW, 16, SRAM word-address width (dat_a).

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
req  in  1  core access request; held until ack
we  in  1  1=store, 0=load
funct3  in  3  RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW)
adr  in  32  byte address
wd  in  32  store data (rs2)
rd_o  out  32  formatted load result; valid with ack
ack  out  1  one-cycle completion pulse
stall  out  1  req & ~ack
err  out  1  misaligned or illegal funct3; valid with ack
dbg_req  in  1  debug word request
dbg_we  in  1  debug write
dbg_a  in  AW  debug word address
dbg_wd  in  32  debug write data
dbg_gnt  out  1  debug access issued this cycle
dbg_rvalid  out  1  debug read data valid
dbg_rd  out  32  raw read word
dat_a  out  AW  SRAM word address
dat_we  out  4  byte write enables
dat_wd  out  32  SRAM write data
dat_re  out  4  byte read enables
dat_rd  in  32  SRAM read data; valid the cycle after dat_re

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, starve counter=0, latched adr[1:0]/funct3=0. While rst=1, all of these are forced to 0: ack, err, stall-independent strobes, dbg_gnt, dbg_rvalid, dat_we, dat_re, rd_o.
- FSM states: IDLE, CORE_WAIT, DBG_WAIT.
- IDLE, winner selection:
  - Core wins if req=1 and (dbg_req=0 or starve<STARVE_MAX).
  - Otherwise debug wins if dbg_req=1.
- IDLE, core issue (cycle T):
  - dat_a = adr[AW+1:2]; adr[31:AW+2] is ignored.
  - Latch adr[1:0], funct3 and we.
  - Go to CORE_WAIT.
  - If misaligned (LH/LHU/SH with adr[0]=1; LW/SW with adr[1:0]≠0) or funct3 is illegal (load 011/110/111, store ≥011): no SRAM strobe; latch err.
- IDLE, debug issue (cycle T): dbg_gnt=1; dat_a=dbg_a; dat_we=4'hF if dbg_we else dat_re=4'hF. Go to DBG_WAIT. Clear starve.
- IDLE, starve counter: increments (saturating at STARVE_MAX) each IDLE cycle in which dbg_req=1 and the core wins.
- CORE_WAIT (T+1): ack=1; err=latched; rd_o=formatted dat_rd for a good load, else 0. Return to IDLE. No new issue is made this cycle; req still high at T+2 is a new access. Core throughput is 1 access per 2 cycles.
- DBG_WAIT (T+1): dbg_rvalid=1 for reads; dbg_rd=dat_rd. Return to IDLE.
- Store lanes:
  - SB: dat_wd={4{wd[7:0]}}, dat_we=1<<adr[1:0].
  - SH: dat_wd={2{wd[15:0]}}, dat_we=adr[1]?4'b1100:4'b0011.
  - SW: dat_wd=wd, dat_we=4'hF.
- Load lanes: dat_re uses the same lane pattern as stores. The selected byte/half is shifted from lane adr[1:0]*8 using the latched offset, then sign-extended (LB/LH) or zero-extended (LBU/LHU).
- Strobe exclusivity: dat_we and dat_re are never nonzero in the same cycle, and both are 0 outside issue cycles.
- Reset mid-operation: rst in CORE_WAIT/DBG_WAIT returns to IDLE with no ack/dbg_rvalid. The requester must re-issue.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum lsu_st_e {IDLE, CORE_WAIT, DBG_WAIT}.
  - Starve-counter width function $clog2(STARVE_MAX+1).
- Sub-module u_lsu_fmt: purely combinational. Store lane alignment/enable generation and load extraction/extension, shared by issue and return paths.

Test Plan:
- SW adr=0x104 wd=0xDEADBEEF -> T: dat_a=0x0041, dat_we=4'hF, dat_wd=0xDEADBEEF; T+1: ack=1, err=0.
- Memory word 0x80FF_1234 at word 0x41; LB adr=0x107 -> dat_re=4'b1000; T+1: rd_o=0xFFFFFF80. LBU same -> 0x00000080. LHU adr=0x104 -> 0x00001234.
- SH adr=0x106 wd=0x0000ABCD -> dat_we=4'b1100, dat_wd=0xABCDABCD.
- LW adr=0x102 -> no dat_re/dat_we; T+1: ack=1, err=1, rd_o=0.
- Core req held back-to-back with dbg_req=1, dbg_a=0x0010 -> core wins 4 contested IDLE cycles. On the 5th, dbg_gnt=1 and dat_a=0x0010. Next IDLE: core wins, starve=0→1.
- Core load issued at T, rst=1 at T+1 -> no ack. After reset: IDLE, all strobes 0. Re-issued load completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM state type and counter sizing for the load/store unit
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, CORE_WAIT, DBG_WAIT} lsu_st_e;

  function automatic int cnt_w(input int m);
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/u_lsu_fmt.sv
// u_lsu_fmt: store lane alignment/enables and load byte/half extraction with extension
module u_lsu_fmt
  import lsu_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  f3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wd_i,
  input  logic [2:0]  lf3_i,
  input  logic [1:0]  loff_i,
  input  logic [31:0] rd_i,
  output logic [3:0]  be_o,
  output logic [31:0] wd_o,
  output logic        bad_o,
  output logic [31:0] ld_o
);
  logic        ill, mis, sx;
  logic [31:0] sh;

  assign ill   = we_i ? (f3_i >= 3'b011) : (f3_i == 3'b011 || f3_i[2:1] == 2'b11);
  assign mis   = (f3_i[1:0] == F3_H[1:0] && off_i[0]) || (f3_i[1:0] == F3_W[1:0] && off_i != 2'b00);
  assign bad_o = ill | mis;

  assign be_o = f3_i[1:0] == F3_B[1:0] ? 4'b0001 << off_i :
                f3_i[1:0] == F3_H[1:0] ? (off_i[1] ? 4'b1100 : 4'b0011) : 4'hF;
  assign wd_o = f3_i[1:0] == F3_B[1:0] ? {4{wd_i[7:0]}} :
                f3_i[1:0] == F3_H[1:0] ? {2{wd_i[15:0]}} : wd_i;

  // Load path uses the offset/funct3 latched at issue, since data returns a cycle later.
  assign sh   = rd_i >> {loff_i, 3'b000};
  assign sx   = ~lf3_i[2];
  assign ld_o = lf3_i[1:0] == F3_B[1:0] ? {{24{sx & sh[7]}}, sh[7:0]} :
                lf3_i[1:0] == F3_H[1:0] ? {{16{sx & sh[15]}}, sh[15:0]} : rd_i;
endmodule

// File: rtl/u_lsu.sv
// u_lsu: core load/store sequencer and data-SRAM arbiter with a starvation-guarded debug port
module u_lsu
  import lsu_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int AW         = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic [2:0]    funct3,
  input  logic [31:0]   adr,
  input  logic [31:0]   wd,
  output logic [31:0]   rd_o,
  output logic          ack,
  output logic          stall,
  output logic          err,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_a,
  input  logic [31:0]   dbg_wd,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [31:0]   dbg_rd,
  output logic [AW-1:0] dat_a,
  output logic [3:0]    dat_we,
  output logic [31:0]   dat_wd,
  output logic [3:0]    dat_re,
  input  logic [31:0]   dat_rd
);
  localparam int            SW   = cnt_w(STARVE_MAX);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  lsu_st_e     st_q;
  logic [SW-1:0] starve_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic        we_q, err_q, dwe_q;
  logic        idle, core_win, dbg_win, core_go, bad;
  logic [3:0]  be;
  logic [31:0] fwd, ld;
  logic        adr_unused;

  assign adr_unused = ^{adr[31:AW+2]};
  assign idle       = st_q == IDLE;
  assign core_win   = idle & req & (~dbg_req | (starve_q < SMAX));
  assign dbg_win    = idle & dbg_req & ~core_win;
  assign core_go    = core_win & ~bad & ~rst;

  u_lsu_fmt u_fmt (
    .we_i  (we),
    .f3_i  (funct3),
    .off_i (adr[1:0]),
    .wd_i  (wd),
    .lf3_i (f3_q),
    .loff_i(off_q),
    .rd_i  (dat_rd),
    .be_o  (be),
    .wd_o  (fwd),
    .bad_o (bad),
    .ld_o  (ld)
  );

  // Arbitration FSM: each issue cycle is followed by exactly one return cycle, then back to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= IDLE;
      starve_q <= '0;
      off_q    <= '0;
      f3_q     <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      dwe_q    <= 1'b0;
    end else begin
      st_q <= core_win ? CORE_WAIT : dbg_win ? DBG_WAIT : IDLE;
      if (core_win) begin
        off_q <= adr[1:0];
        f3_q  <= funct3;
        we_q  <= we;
        err_q <= bad;
      end
      if (dbg_win) dwe_q <= dbg_we;
      if (dbg_win) starve_q <= '0;
      else if (core_win && dbg_req && starve_q < SMAX) starve_q <= starve_q + 1'b1;
    end
  end

  assign ack        = (st_q == CORE_WAIT) & ~rst;
  assign err        = ack & err_q;
  assign rd_o       = (ack & ~err_q & ~we_q) ? ld : '0;
  assign stall      = req & ~ack;
  assign dbg_gnt    = dbg_win & ~rst;
  assign dbg_rvalid = (st_q == DBG_WAIT) & ~dwe_q & ~rst;
  assign dbg_rd     = dat_rd;
  assign dat_a      = dbg_win ? dbg_a : adr[AW+1:2];
  assign dat_wd     = dbg_win ? dbg_wd : fwd;
  assign dat_we     = (core_go & we) ? be : (dbg_gnt & dbg_we) ? 4'hF : 4'h0;
  assign dat_re     = (core_go & ~we) ? be : (dbg_gnt & ~dbg_we) ? 4'hF : 4'h0;
endmodule

// File: tb/tb_u_lsu.sv
// tb_u_lsu: directed stimulus with scoreboarded core/debug responses for u_lsu
module tb_u_lsu;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] adr = '0, wd = '0;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [15:0] dbg_a = '0;
  logic [31:0] dbg_wd = '0;
  logic [31:0] rd_o, dbg_rd, dat_wd;
  logic        ack, stall, err, dbg_gnt, dbg_rvalid;
  logic [15:0] dat_a;
  logic [3:0]  dat_we, dat_re;
  logic [31:0] dat_rd = '0;
  logic [31:0] mem [0:255];
  logic [32:0] cq[$];
  logic [31:0] dq[$];
  logic [32:0] e_c;
  logic [31:0] e_d;
  int          n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  u_lsu #(.STARVE_MAX(4), .AW(16)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .adr(adr), .wd(wd),
    .rd_o(rd_o), .ack(ack), .stall(stall), .err(err),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_a(dbg_a), .dbg_wd(dbg_wd),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rd(dbg_rd),
    .dat_a(dat_a), .dat_we(dat_we), .dat_wd(dat_wd), .dat_re(dat_re), .dat_rd(dat_rd)
  );

  // SRAM with one-cycle read latency and byte write enables
  always @(posedge clk) begin
    if (dat_re != 4'h0) dat_rd <= mem[dat_a[7:0]];
    for (int b = 0; b < 4; b++)
      if (dat_we[b]) mem[dat_a[7:0]][8*b +: 8] <= dat_wd[8*b +: 8];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard whenever the DUT presents a completion
  always @(negedge clk) begin
    if (ack) begin
      if (cq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_ack: got ack=1 expected no ack");
      end else begin
        e_c = cq.pop_front();
        chk("ack_rd", rd_o, e_c[31:0]);
        chk("ack_err", {31'b0, err}, {31'b0, e_c[32]});
      end
    end
    if (dbg_rvalid) begin
      if (dq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_dbg_rvalid: got 1 expected 0");
      end else begin
        e_d = dq.pop_front();
        chk("dbg_rd", dbg_rd, e_d);
      end
    end
  end

  task automatic core(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] xwe, input logic [3:0] xre, input logic [31:0] xwd,
                      input logic [31:0] xrd, input logic xerr, input string nm);
    cq.push_back({xerr, xrd});
    req = 1'b1; we = w; funct3 = f; adr = a; wd = d;
    @(negedge clk);
    chk({nm, "_dat_a"}, {16'b0, dat_a}, {16'b0, a[17:2]});
    chk({nm, "_dat_we"}, {28'b0, dat_we}, {28'b0, xwe});
    chk({nm, "_dat_re"}, {28'b0, dat_re}, {28'b0, xre});
    if (xwe != 4'h0) chk({nm, "_dat_wd"}, dat_wd, xwd);
    chk({nm, "_stall"}, {31'b0, stall}, 32'd1);
    @(posedge clk); #1 req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic dbg(input logic w, input logic [15:0] a, input logic [31:0] d, input logic [31:0] xrd);
    if (!w) dq.push_back(xrd);
    dbg_req = 1'b1; dbg_we = w; dbg_a = a; dbg_wd = d;
    @(negedge clk);
    chk("dbg_gnt", {31'b0, dbg_gnt}, 32'd1);
    chk("dbg_dat_a", {16'b0, dat_a}, {16'b0, a});
    chk("dbg_dat_we", {28'b0, dat_we}, w ? 32'hF : 32'h0);
    chk("dbg_dat_re", {28'b0, dat_re}, w ? 32'h0 : 32'hF);
    @(posedge clk); #1 dbg_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    req = 1'b1; funct3 = 3'b010; adr = 32'h104;
    repeat (2) begin
      @(negedge clk);
      chk("rst_ack", {31'b0, ack}, 32'd0);
      chk("rst_dat_re", {28'b0, dat_re}, 32'd0);
      chk("rst_dbg_gnt", {31'b0, dbg_gnt}, 32'd0);
    end
    @(posedge clk); #1 rst = 1'b0; req = 1'b0;

    core(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 4'hF, 4'h0, 32'hDEADBEEF, 32'h0, 1'b0, "sw");
    dbg(1'b0, 16'h0041, 32'h0, 32'hDEADBEEF);
    dbg(1'b1, 16'h0041, 32'h80FF1234, 32'h0);
    dbg(1'b1, 16'h0010, 32'h5A5A0000, 32'h0);
    core(1'b0, 3'b000, 32'h107, 32'h0, 4'h0, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b0, "lb");
    core(1'b0, 3'b100, 32'h107, 32'h0, 4'h0, 4'b1000, 32'h0, 32'h00000080, 1'b0, "lbu");
    core(1'b0, 3'b101, 32'h104, 32'h0, 4'h0, 4'b0011, 32'h0, 32'h00001234, 1'b0, "lhu");
    core(1'b0, 3'b001, 32'h106, 32'h0, 4'h0, 4'b1100, 32'h0, 32'hFFFF80FF, 1'b0, "lh");
    core(1'b0, 3'b000, 32'h105, 32'h0, 4'h0, 4'b0010, 32'h0, 32'h00000012, 1'b0, "lb1");
    core(1'b1, 3'b001, 32'h106, 32'h0000ABCD, 4'b1100, 4'h0, 32'hABCDABCD, 32'h0, 1'b0, "sh");
    core(1'b0, 3'b010, 32'h104, 32'h0, 4'h0, 4'hF, 32'h0, 32'hABCD1234, 1'b0, "lw");
    core(1'b1, 3'b000, 32'h105, 32'h00000077, 4'b0010, 4'h0, 32'h77777777, 32'h0, 1'b0, "sb");
    core(1'b0, 3'b010, 32'h104, 32'h0, 4'h0, 4'hF, 32'h0, 32'hABCD7734, 1'b0, "lw2");
    core(1'b0, 3'b010, 32'h102, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, "lw_mis");
    core(1'b0, 3'b101, 32'h105, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, "lhu_mis");
    core(1'b0, 3'b011, 32'h104, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, "ld_ill");
    core(1'b1, 3'b011, 32'h104, 32'h1, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, "st_ill");
    core(1'b0, 3'b010, 32'h104, 32'h0, 4'h0, 4'hF, 32'h0, 32'hABCD7734, 1'b0, "lw3");

    repeat (5) cq.push_back({1'b0, 32'hABCD7734});
    dq.push_back(32'h5A5A0000);
    req = 1'b1; we = 1'b0; funct3 = 3'b010; adr = 32'h104;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_a = 16'h0010;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      chk($sformatf("starve_gnt%0d", i), {31'b0, dbg_gnt}, (i == 8) ? 32'd1 : 32'd0);
      if (i == 8) chk("starve_dbg_a", {16'b0, dat_a}, 32'h0010);
      if (i == 10) chk("starve_core_a", {16'b0, dat_a}, 32'h0041);
      @(posedge clk);
    end
    #1 req = 1'b0; dbg_req = 1'b0;
    @(posedge clk); #1;

    req = 1'b1; we = 1'b0; funct3 = 3'b010; adr = 32'h104;
    @(posedge clk); #1 req = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("midrst_ack", {31'b0, ack}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("postrst_we", {28'b0, dat_we}, 32'd0);
    chk("postrst_re", {28'b0, dat_re}, 32'd0);
    chk("postrst_ack", {31'b0, ack}, 32'd0);
    @(posedge clk); #1;
    core(1'b0, 3'b010, 32'h104, 32'h0, 4'h0, 4'hF, 32'h0, 32'hABCD7734, 1'b0, "reissue");

    repeat (3) @(posedge clk);
    chk("core_q_empty", cq.size(), 32'd0);
    chk("dbg_q_empty", dq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
